reg_writeback_ctrl: RTL and testbench

//  Write-side controller for the 16x16 register file. Buffers results from the ALU and

---
 rtl/wb_pkg.sv | 10 +
 rtl/wb_dual_push_fifo.sv | 55 +++++
 rtl/reg_writeback_ctrl.sv | 80 ++++++++
 tb/tb_reg_writeback_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and queue entry type for the register write-back path
package wb_pkg;
    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 16;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_dual_push_fifo.sv
// rtl/wb_dual_push_fifo.sv - in-order queue accepting 0/1/2 pushes and 0/1 pop per cycle
module wb_dual_push_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push0_i,
    input  wb_entry_t        push0_data_i,
    input  logic             push1_i,
    input  wb_entry_t        push1_data_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] count_o,
    output wb_entry_t        entries_o [DEPTH],
    output logic [DEPTH-1:0] valid_o
);
    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic [1:0]       n_push;
    logic [PTR_W-1:0] push1_idx;

    assign n_push    = {1'b0, push0_i} + {1'b0, push1_i};
    assign push1_idx = push0_i ? tail_q + PTR_W'(1) : tail_q;
    assign count_o   = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(pop_i);
            tail_q  <= tail_q + PTR_W'(n_push);
            count_q <= count_q + CNT_W'(n_push) - CNT_W'(pop_i);
        end
    end

    // Storage needs no reset: occupancy is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (push0_i) mem_q[tail_q]    <= push0_data_i;
        if (push1_i) mem_q[push1_idx] <= push1_data_i;
    end

    // Entries presented oldest-first: index 0 is the head.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            entries_o[k] = mem_q[head_q + PTR_W'(k)];
            valid_o[k]   = CNT_W'(k) < count_q;
        end
    end
endmodule

// File: rtl/reg_writeback_ctrl.sv
// rtl/reg_writeback_ctrl.sv - buffers ALU/load results, drains to the register file, forwards pending data
module reg_writeback_ctrl
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              wr_hold,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] AddrC,
    output logic [DATA_W-1:0] BusC,
    input  logic [ADDR_W-1:0] AddrA,
    output logic              fwdA_hit,
    output logic [DATA_W-1:0] fwdA_data,
    input  logic [ADDR_W-1:0] AddrB,
    output logic              fwdB_hit,
    output logic [DATA_W-1:0] fwdB_data,
    output logic [CNT_W-1:0]  count
);
    wb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] free;
    logic             mem_push, alu_push;

    assign free      = CNT_W'(DEPTH) - count_q;
    assign mem_ready = ~rst & (free != '0);
    assign alu_ready = ~rst & ((free >= CNT_W'(2)) | ((free == CNT_W'(1)) & ~mem_valid));
    assign mem_push  = mem_valid & mem_ready;
    assign alu_push  = alu_valid & alu_ready;
    assign count     = count_q;

    // MEM goes in the first push slot so it is older than a same-edge ALU result.
    wb_dual_push_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push0_i      (mem_push),
        .push0_data_i ('{addr: mem_addr, data: mem_data}),
        .push1_i      (alu_push),
        .push1_data_i ('{addr: alu_addr, data: alu_data}),
        .pop_i        (RegWrite),
        .count_o      (count_q),
        .entries_o    (entries),
        .valid_o      (valid)
    );

    assign RegWrite = ~rst & valid[0] & ~wr_hold;
    assign AddrC    = RegWrite ? entries[0].addr : '0;
    assign BusC     = RegWrite ? entries[0].data : '0;

    // Scanning oldest to youngest lets the last match overwrite earlier ones.
    always_comb begin
        fwdA_hit  = 1'b0;
        fwdA_data = '0;
        fwdB_hit  = 1'b0;
        fwdB_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!rst && valid[k] && entries[k].addr == AddrA) begin
                fwdA_hit  = 1'b1;
                fwdA_data = entries[k].data;
            end
            if (!rst && valid[k] && entries[k].addr == AddrB) begin
                fwdB_hit  = 1'b1;
                fwdB_data = entries[k].data;
            end
        end
    end
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb/tb_reg_writeback_ctrl.sv - randomized bench for reg_writeback_ctrl against a queue model
module tb_reg_writeback_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, mem_valid, alu_valid, wr_hold;
    logic [3:0]  mem_addr, alu_addr, AddrA, AddrB, AddrC;
    logic [15:0] mem_data, alu_data, BusC, fwdA_data, fwdB_data;
    logic        mem_ready, alu_ready, RegWrite, fwdA_hit, fwdB_hit;
    logic [2:0]  count;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
    } ent_t;

    ent_t        q[$];
    logic [15:0] ref_rf [16] = '{default: 16'h0};
    logic [15:0] rf [16]     = '{default: 16'h0};
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (RegWrite) rf[AddrC] <= BusC;

    reg_writeback_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .wr_hold(wr_hold), .RegWrite(RegWrite), .AddrC(AddrC), .BusC(BusC),
        .AddrA(AddrA), .fwdA_hit(fwdA_hit), .fwdA_data(fwdA_data),
        .AddrB(AddrB), .fwdB_hit(fwdB_hit), .fwdB_data(fwdB_data),
        .count(count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit mv, input logic [3:0] ma, input logic [15:0] md,
                        input bit av, input logic [3:0] aa, input logic [15:0] ad,
                        input bit hold, input logic [3:0] ra, input logic [3:0] rb);
        int          free;
        bit          mr, ar, we, ha, hb;
        logic [15:0] da, db;
        logic [3:0]  ea;
        logic [15:0] ed;
        ent_t        e;
        rst = r; mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        wr_hold = hold; AddrA = ra; AddrB = rb;
        #1;
        free = DEPTH - q.size();
        mr = !r && free >= 1;
        ar = !r && (free >= 2 || (free == 1 && !mv));
        we = !r && q.size() > 0 && !hold;
        ea = 4'h0; ed = 16'h0;
        if (we) begin ea = q[0].a; ed = q[0].d; end
        ha = 0; hb = 0; da = 16'h0; db = 16'h0;
        if (!r) begin
            foreach (q[i]) begin
                if (q[i].a == ra) begin ha = 1; da = q[i].d; end
                if (q[i].a == rb) begin hb = 1; db = q[i].d; end
            end
        end
        check("count",     32'(count),     32'(q.size()));
        check("mem_ready", 32'(mem_ready), 32'(mr));
        check("alu_ready", 32'(alu_ready), 32'(ar));
        check("RegWrite",  32'(RegWrite),  32'(we));
        check("AddrC",     32'(AddrC),     32'(ea));
        check("BusC",      32'(BusC),      32'(ed));
        check("fwdA_hit",  32'(fwdA_hit),  32'(ha));
        check("fwdA_data", 32'(fwdA_data), 32'(da));
        check("fwdB_hit",  32'(fwdB_hit),  32'(hb));
        check("fwdB_data", 32'(fwdB_data), 32'(db));
        @(posedge clk);
        if (r) begin
            q.delete();
        end else begin
            if (we) begin
                e = q.pop_front();
                ref_rf[e.a] = e.d;
            end
            if (mv && mr) q.push_back('{a: ma, d: md});
            if (av && ar) q.push_back('{a: aa, d: ad});
        end
        #1;
    endtask

    task automatic idle(input bit hold);
        step(0, 0, 4'h0, 16'h0, 0, 4'h0, 16'h0, hold, 4'h0, 4'h0);
    endtask

    initial begin
        rst = 1; mem_valid = 0; alu_valid = 0; wr_hold = 0;
        mem_addr = 0; mem_data = 0; alu_addr = 0; alu_data = 0; AddrA = 0; AddrB = 0;
        repeat (2) @(posedge clk);
        #1;
        step(1, 1, 4'h1, 16'h1, 1, 4'h2, 16'h2, 0, 4'h0, 4'h0);

        // single load into empty queue
        step(0, 1, 4'h3, 16'h00AA, 0, 4'h0, 16'h0, 0, 4'h3, 4'h0);
        check("t1_regwrite", 32'(RegWrite), 32'd1);
        check("t1_addrc",    32'(AddrC),    32'd3);
        check("t1_busc",     32'(BusC),     32'h00AA);
        idle(0);
        idle(0);
        check("t1_rf3", 32'(rf[3]), 32'h00AA);

        // fill under hold, then release in order
        step(0, 1, 4'h1, 16'h1111, 1, 4'h2, 16'h2222, 1, 4'h0, 4'h0);
        step(0, 1, 4'h5, 16'h5555, 1, 4'h6, 16'h6666, 1, 4'h5, 4'h6);
        step(0, 1, 4'h9, 16'h9999, 1, 4'hA, 16'hAAAA, 1, 4'h1, 4'h2);
        repeat (5) idle(0);

        // count 3, both valid: only mem fits
        step(0, 1, 4'h1, 16'h0101, 1, 4'h2, 16'h0202, 1, 4'h0, 4'h0);
        step(0, 1, 4'h3, 16'h0303, 0, 4'h0, 16'h0, 1, 4'h0, 4'h0);
        step(0, 1, 4'h4, 16'h0404, 1, 4'h5, 16'h0505, 1, 4'h4, 4'h5);
        check("t3_count", 32'(count), 32'd4);
        repeat (5) idle(0);

        // duplicate destination: youngest forwarded, last write wins
        step(0, 1, 4'h7, 16'h0001, 0, 4'h0, 16'h0, 1, 4'h7, 4'h8);
        step(0, 0, 4'h0, 16'h0, 1, 4'h7, 16'h0002, 1, 4'h7, 4'h8);
        step(0, 0, 4'h0, 16'h0, 0, 4'h0, 16'h0, 1, 4'h7, 4'h8);
        check("t4_fwdA", 32'(fwdA_data), 32'h0002);
        repeat (3) idle(0);
        check("t4_rf7", 32'(rf[7]), 32'h0002);

        // reset with pending writes, both with and without hold
        step(0, 1, 4'hC, 16'hDEAD, 1, 4'hD, 16'hBEEF, 1, 4'h0, 4'h0);
        step(0, 1, 4'hE, 16'hCAFE, 0, 4'h0, 16'h0, 1, 4'h0, 4'h0);
        step(1, 1, 4'hC, 16'h1234, 1, 4'hD, 16'h5678, 1, 4'hC, 4'hD);
        idle(0);
        step(0, 1, 4'hC, 16'hF00D, 1, 4'hD, 16'hFEED, 1, 4'h0, 4'h0);
        step(1, 0, 4'h0, 16'h0, 0, 4'h0, 16'h0, 0, 4'hC, 4'hD);
        idle(0);
        check("t5_rfC", 32'(rf[12]), 32'h0);

        // sixteen back-to-back ALU writes then read sweep
        for (int i = 0; i < 16; i++)
            step(0, 0, 4'h0, 16'h0, 1, 4'(i), 16'((i + 1) % 16), 0, 4'h0, 4'h0);
        repeat (3) idle(0);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 4'h0, 16'h0, 0, 4'h0, 16'h0, 0, 4'(i), 4'((i + 1) % 16));
            check("t6_rfA", 32'(rf[AddrA]), 32'((i + 1) % 16));
            check("t6_rfB", 32'(rf[AddrB]), 32'((i + 2) % 16));
        end

        // random traffic
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 49) == 0,
                 1'($urandom), 4'($urandom), 16'($urandom),
                 1'($urandom), 4'($urandom), 16'($urandom),
                 $urandom_range(0, 3) == 0, 4'($urandom), 4'($urandom));
        end
        repeat (DEPTH + 2) idle(0);
        check("drained", 32'(count), 32'd0);
        for (int i = 0; i < 16; i++) check("rf_final", 32'(rf[i]), 32'(ref_rf[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
